// File: rtl/axi_slave_wr_ch.sv
// AXI4 slave write-channel engine: accepts one AW/W burst at a time, expands
// FIXED/INCR/WRAP bursts into per-beat word writes on an SRAM-style port and
// returns the B response.
//
// state | meaning
// IDLE  | awready asserted, waiting for a write address
// DATA  | wready asserted, accepting beats and issuing memory writes
// RESP  | bvalid asserted, holding the response until bready
module axi_slave_wr_ch #(
   parameter int ID_W   = 8,
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_W-1:0]       s_axi_awid,
   input  logic [ADDR_W-1:0]     s_axi_awaddr,
   input  logic [7:0]            s_axi_awlen,
   input  logic [2:0]            s_axi_awsize,
   input  logic [1:0]            s_axi_awburst,
   input  logic                  s_axi_awlock,
   input  logic [3:0]            s_axi_awcache,
   input  logic [2:0]            s_axi_awprot,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_W-1:0]     s_axi_wdata,
   input  logic [DATA_W/8-1:0]   s_axi_wstrb,
   input  logic                  s_axi_wlast,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [ID_W-1:0]       s_axi_bid,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wstrb
);

   localparam int STRB_W = DATA_W / 8;
   localparam int LSB_W  = $clog2(STRB_W);

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      RESP
   } state_t;

   state_t              state_q;
   logic                awready_q;
   logic                wready_q;
   logic                bvalid_q;
   logic [1:0]          bresp_q;
   logic                mem_we_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [STRB_W-1:0]   mem_wstrb_q;

   logic [ID_W-1:0]     id_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   base_q;
   logic [7:0]          len_q;
   logic [2:0]          size_q;
   logic [1:0]          burst_q;
   logic [7:0]          cnt_q;
   logic                err_q;
   logic                ill_q;

   logic [ADDR_W-1:0]   step_d;
   logic [ADDR_W-1:0]   wrap_mask_d;
   logic [ADDR_W-1:0]   incr_d;
   logic [ADDR_W-1:0]   next_addr_d;
   logic [ADDR_W-1:0]   aw_mask_d;
   logic [ADDR_W-1:0]   aw_base_d;
   logic                aw_ill_d;
   logic                aw_hs;
   logic                w_hs;
   logic                b_hs;
   logic                final_beat;

   // Protection/cache/lock attributes carry no meaning for this memory.
   logic                unused_attr;
   assign unused_attr = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot};

   assign aw_hs      = s_axi_awvalid & awready_q;
   assign w_hs       = s_axi_wvalid & wready_q;
   assign b_hs       = bvalid_q & s_axi_bready;
   assign final_beat = (cnt_q == len_q);

   // Wrap container geometry of the incoming request; base is the
   // container-aligned start address.
   assign aw_mask_d = ((ADDR_W'(s_axi_awlen) + ADDR_W'(1)) << s_axi_awsize) - ADDR_W'(1);
   assign aw_base_d = s_axi_awaddr & ~aw_mask_d;

   // Requests this memory cannot honour are still drained but never written.
   always_comb begin
      aw_ill_d = 1'b0;
      if (int'(s_axi_awsize) > LSB_W)
         aw_ill_d = 1'b1;
      if (s_axi_awburst == BURST_RSVD)
         aw_ill_d = 1'b1;
      if ((s_axi_awburst == BURST_WRAP) &&
          !((s_axi_awlen == 8'd1) || (s_axi_awlen == 8'd3) ||
            (s_axi_awlen == 8'd7) || (s_axi_awlen == 8'd15)))
         aw_ill_d = 1'b1;
   end

   assign step_d      = ADDR_W'(1) << size_q;
   assign wrap_mask_d = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
   assign incr_d      = addr_q + step_d;

   // Beat address advance; all arithmetic wraps modulo the address width.
   always_comb begin
      next_addr_d = addr_q;
      case (burst_q)
         BURST_FIXED: next_addr_d = addr_q;
         BURST_INCR:  next_addr_d = incr_d;
         BURST_WRAP:  next_addr_d = base_q + ((incr_d - base_q) & wrap_mask_d);
         default:     next_addr_d = addr_q;
      endcase
   end

   // Channel FSM with registered handshake and memory-port outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         awready_q   <= 1'b0;
         wready_q    <= 1'b0;
         bvalid_q    <= 1'b0;
         bresp_q     <= RESP_OKAY;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
         id_q        <= '0;
         addr_q      <= '0;
         base_q      <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         ill_q       <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (aw_hs) begin
                  id_q      <= s_axi_awid;
                  addr_q    <= s_axi_awaddr;
                  base_q    <= aw_base_d;
                  len_q     <= s_axi_awlen;
                  size_q    <= s_axi_awsize;
                  burst_q   <= s_axi_awburst;
                  cnt_q     <= '0;
                  err_q     <= aw_ill_d;
                  ill_q     <= aw_ill_d;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  state_q   <= DATA;
               end else begin
                  awready_q <= 1'b1;
               end
            end
            DATA: begin
               if (w_hs) begin
                  mem_we_q    <= ~ill_q;
                  mem_addr_q  <= addr_q & ~ADDR_W'(STRB_W - 1);
                  mem_wdata_q <= s_axi_wdata;
                  mem_wstrb_q <= s_axi_wstrb;
                  addr_q      <= next_addr_d;
                  cnt_q       <= cnt_q + 8'd1;
                  if (final_beat) begin
                     wready_q <= 1'b0;
                     bvalid_q <= 1'b1;
                     bresp_q  <= (err_q || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
                     state_q  <= RESP;
                  end else if (s_axi_wlast) begin
                     err_q <= 1'b1;
                  end
               end
            end
            RESP: begin
               if (b_hs) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bid     = id_q;
   assign s_axi_bresp   = bresp_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_axi_slave_wr_ch.sv
// Bench for axi_slave_wr_ch: burst table plus directed back-pressure and
// mid-burst reset sequences; memory writes and B responses are checked
// against expectation queues filled by the stimulus.
module tb_axi_slave_wr_ch;

   localparam int ID_W   = 8;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [ID_W-1:0]      s_axi_awid = '0;
   logic [ADDR_W-1:0]    s_axi_awaddr = '0;
   logic [7:0]           s_axi_awlen = '0;
   logic [2:0]           s_axi_awsize = '0;
   logic [1:0]           s_axi_awburst = '0;
   logic                 s_axi_awlock = 1'b0;
   logic [3:0]           s_axi_awcache = '0;
   logic [2:0]           s_axi_awprot = '0;
   logic                 s_axi_awvalid = 1'b0;
   logic                 s_axi_awready;
   logic [DATA_W-1:0]    s_axi_wdata = '0;
   logic [DATA_W/8-1:0]  s_axi_wstrb = '0;
   logic                 s_axi_wlast = 1'b0;
   logic                 s_axi_wvalid = 1'b0;
   logic                 s_axi_wready;
   logic [ID_W-1:0]      s_axi_bid;
   logic [1:0]           s_axi_bresp;
   logic                 s_axi_bvalid;
   logic                 s_axi_bready = 1'b1;
   logic                 mem_we;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic [DATA_W/8-1:0]  mem_wstrb;

   always #5 clk = ~clk;

   axi_slave_wr_ch #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axi_awid    (s_axi_awid),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awlen   (s_axi_awlen),
      .s_axi_awsize  (s_axi_awsize),
      .s_axi_awburst (s_axi_awburst),
      .s_axi_awlock  (s_axi_awlock),
      .s_axi_awcache (s_axi_awcache),
      .s_axi_awprot  (s_axi_awprot),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wlast   (s_axi_wlast),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bid     (s_axi_bid),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb)
   );

   typedef struct packed {
      logic [7:0]        id;
      logic [15:0]       addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
      logic [7:0]        bad_beat;   // beat whose wlast is inverted, FF = none
      logic              gaps;
      logic [31:0]       d0;
      logic              writes;
      logic [1:0]        resp;
      logic [3:0][15:0]  ea;
   } vec_t;

   typedef struct packed {
      logic [15:0] a;
      logic [31:0] d;
      logic [3:0]  s;
   } wr_t;

   typedef struct packed {
      logic [7:0] id;
      logic [1:0] resp;
      logic       we;
   } b_t;

   localparam int NV = 13;
   vec_t vecs [NV];
   wr_t  wq[$];
   b_t   bq[$];
   wr_t  w_exp;
   b_t   b_exp;
   int   checks = 0;
   int   errors = 0;
   logic prev_bvalid = 1'b0;

   function automatic vec_t mk(input logic [7:0] id, input logic [15:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic [7:0] bad,
                               input logic gaps, input logic [31:0] d0,
                               input logic writes, input logic [1:0] resp,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [15:0] a2, input logic [15:0] a3);
      vec_t v;
      v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
      v.bad_beat = bad; v.gaps = gaps; v.d0 = d0; v.writes = writes; v.resp = resp;
      v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
      return v;
   endfunction

   // Output monitor: memory writes, B timing relative to the last write, B contents.
   always @(negedge clk) begin
      if (mem_we) begin
         checks++;
         if (wq.size() == 0) begin
            errors++;
            $display("FAIL mem_we_unexpected: addr=%h data=%h strb=%h, no write expected", mem_addr, mem_wdata, mem_wstrb);
         end else begin
            w_exp = wq.pop_front();
            if ({mem_addr, mem_wdata, mem_wstrb} !== {w_exp.a, w_exp.d, w_exp.s}) begin
               errors++;
               $display("FAIL mem_write: got addr=%h data=%h strb=%h, expected addr=%h data=%h strb=%h",
                        mem_addr, mem_wdata, mem_wstrb, w_exp.a, w_exp.d, w_exp.s);
            end
         end
      end
      if (s_axi_bvalid && !prev_bvalid && bq.size() != 0) begin
         checks++;
         if (mem_we !== bq[0].we) begin
            errors++;
            $display("FAIL b_with_last_we: mem_we=%b at bvalid rise, expected %b", mem_we, bq[0].we);
         end
      end
      if (s_axi_bvalid && s_axi_bready) begin
         checks++;
         if (bq.size() == 0) begin
            errors++;
            $display("FAIL b_unexpected: bid=%h bresp=%b, no response expected", s_axi_bid, s_axi_bresp);
         end else begin
            b_exp = bq.pop_front();
            if ({s_axi_bid, s_axi_bresp} !== {b_exp.id, b_exp.resp}) begin
               errors++;
               $display("FAIL b_resp: got bid=%h bresp=%b, expected bid=%h bresp=%b",
                        s_axi_bid, s_axi_bresp, b_exp.id, b_exp.resp);
            end
         end
      end
      prev_bvalid = s_axi_bvalid;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the AW handshake edge.
   task automatic do_aw(input vec_t v);
      int t;
      s_axi_awid    = v.id;
      s_axi_awaddr  = v.addr;
      s_axi_awlen   = v.len;
      s_axi_awsize  = v.size;
      s_axi_awburst = v.burst;
      s_axi_awvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_axi_awready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("aw_handshake", 64'(s_axi_awready), 64'd1);
      @(posedge clk);
      #1 s_axi_awvalid = 1'b0;
   endtask

   task automatic do_beats(input vec_t v, input int nbeats);
      int t;
      logic [31:0] d;
      logic [3:0]  s;
      for (int b = 0; b < nbeats; b++) begin
         if (v.gaps) begin
            s_axi_wvalid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
         d = (b == 0) ? v.d0 : $urandom;
         s = (b == 0) ? 4'hF : 4'($urandom_range(1, 15));
         s_axi_wdata  = d;
         s_axi_wstrb  = s;
         s_axi_wlast  = (b == int'(v.len)) ^ (b == int'(v.bad_beat));
         s_axi_wvalid = 1'b1;
         t = 0;
         @(negedge clk);
         while (!s_axi_wready && t < 50) begin
            @(negedge clk);
            t++;
         end
         chk("w_handshake", 64'(s_axi_wready), 64'd1);
         if (v.writes) wq.push_back('{a: v.ea[b], d: d, s: s});
         @(posedge clk);
         #1;
      end
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while ((bq.size() != 0 || wq.size() != 0) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_queues", 64'(bq.size() + wq.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v);
      bq.push_back('{id: v.id, resp: v.resp, we: v.writes});
      do_aw(v);
      do_beats(v, int'(v.len) + 1);
      wait_done();
   endtask

   initial begin
      vec_t v;
      vecs[0]  = mk(8'h11, 16'h0100, 8'd0, 3'd2, 2'b01, 8'hFF, 1'b0, 32'hDEADBEEF, 1'b1, 2'b00, 16'h0100, 16'h0, 16'h0, 16'h0);
      vecs[1]  = mk(8'h22, 16'h0010, 8'd3, 3'd2, 2'b01, 8'hFF, 1'b1, 32'h01010101, 1'b1, 2'b00, 16'h0010, 16'h0014, 16'h0018, 16'h001C);
      vecs[2]  = mk(8'h33, 16'h0038, 8'd3, 3'd2, 2'b10, 8'hFF, 1'b0, 32'h02020202, 1'b1, 2'b00, 16'h0038, 16'h003C, 16'h0030, 16'h0034);
      vecs[3]  = mk(8'h44, 16'h0038, 8'd2, 3'd2, 2'b10, 8'hFF, 1'b0, 32'h03030303, 1'b0, 2'b10, 16'h0, 16'h0, 16'h0, 16'h0);
      vecs[4]  = mk(8'h55, 16'h0200, 8'd2, 3'd2, 2'b00, 8'hFF, 1'b1, 32'h04040404, 1'b1, 2'b00, 16'h0200, 16'h0200, 16'h0200, 16'h0);
      vecs[5]  = mk(8'h66, 16'hFFFC, 8'd1, 3'd2, 2'b01, 8'hFF, 1'b0, 32'h05050505, 1'b1, 2'b00, 16'hFFFC, 16'h0000, 16'h0, 16'h0);
      vecs[6]  = mk(8'h77, 16'h0040, 8'd3, 3'd2, 2'b01, 8'd1,  1'b0, 32'h06060606, 1'b1, 2'b10, 16'h0040, 16'h0044, 16'h0048, 16'h004C);
      vecs[7]  = mk(8'h88, 16'h0080, 8'd1, 3'd2, 2'b11, 8'hFF, 1'b0, 32'h07070707, 1'b0, 2'b10, 16'h0, 16'h0, 16'h0, 16'h0);
      vecs[8]  = mk(8'h99, 16'h0080, 8'd1, 3'd3, 2'b01, 8'hFF, 1'b0, 32'h08080808, 1'b0, 2'b10, 16'h0, 16'h0, 16'h0, 16'h0);
      vecs[9]  = mk(8'hA5, 16'h0005, 8'd3, 3'd0, 2'b01, 8'hFF, 1'b0, 32'h09090909, 1'b1, 2'b00, 16'h0004, 16'h0004, 16'h0004, 16'h0008);
      vecs[10] = mk(8'hB6, 16'h0300, 8'd1, 3'd2, 2'b01, 8'd1,  1'b0, 32'h0A0A0A0A, 1'b1, 2'b10, 16'h0300, 16'h0304, 16'h0, 16'h0);
      vecs[11] = mk(8'hC7, 16'h0002, 8'd3, 3'd1, 2'b01, 8'hFF, 1'b1, 32'h0B0B0B0B, 1'b1, 2'b00, 16'h0000, 16'h0004, 16'h0004, 16'h0008);
      vecs[12] = mk(8'hD8, 16'h000C, 8'd1, 3'd2, 2'b10, 8'hFF, 1'b0, 32'h0C0C0C0C, 1'b1, 2'b00, 16'h000C, 16'h0008, 16'h0, 16'h0);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
                                mem_we, mem_addr, mem_wdata, mem_wstrb}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("awready_after_reset", 64'(s_axi_awready), 64'd1);

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // B back-pressure: response held stable, no new address accepted
      v = mk(8'hE1, 16'h0400, 8'd0, 3'd2, 2'b01, 8'hFF, 1'b0, 32'hCAFEF00D, 1'b1, 2'b00, 16'h0400, 16'h0, 16'h0, 16'h0);
      s_axi_bready = 1'b0;
      bq.push_back('{id: v.id, resp: v.resp, we: v.writes});
      do_aw(v);
      do_beats(v, 1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold", 64'({s_axi_bvalid, s_axi_bid, s_axi_bresp, s_axi_awready, s_axi_wready}),
             64'({1'b1, 8'hE1, 2'b00, 1'b0, 1'b0}));
      end
      @(posedge clk);
      #1 s_axi_bready = 1'b1;
      wait_done();
      chk("awready_after_b", 64'(s_axi_awready), 64'd1);

      // Reset in the middle of a burst: no B, outputs cleared, channel reopens
      v = mk(8'hF2, 16'h0500, 8'd3, 3'd2, 2'b01, 8'hFF, 1'b0, 32'h12345678, 1'b1, 2'b00, 16'h0500, 16'h0504, 16'h0508, 16'h050C);
      do_aw(v);
      do_beats(v, 1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midburst_reset_outputs", 64'({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
                                         mem_we, mem_addr, mem_wdata, mem_wstrb}), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("awready_after_midreset", 64'({s_axi_awready, s_axi_wready}), 64'b10);
      repeat (10) begin
         @(negedge clk);
         chk("no_b_after_reset", 64'(s_axi_bvalid), 64'd0);
      end
      chk("queues_after_reset", 64'(wq.size() + bq.size()), 64'd0);

      @(posedge clk);
      #1;
      run_vec(vecs[0]);
      run_vec(vecs[2]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axi_slave_wr_ch.md
Name: axi_slave_wr_ch

Overview:
- AXI4 slave write-channel engine; the DUT-side consumer of the master agent's AW/W/B signals.
- Accepts one write burst at a time and expands FIXED/INCR/WRAP bursts into per-beat word writes on a simple SRAM-style port.
- Returns the B response.
- Sits between the master-facing s_axi_* pins and the on-chip memory array.

Parameters:
ID_W, 8, AWID/BID width
ADDR_W, 16, byte address width
DATA_W, 32, data width (strobe width DATA_W/8)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-low
s_axi_awid  in  ID_W  write ID
s_axi_awaddr  in  ADDR_W  start byte address
s_axi_awlen  in  8  beats-1
s_axi_awsize  in  3  log2 bytes/beat
s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
s_axi_awlock/awcache/awprot  in  1/4/3  accepted, ignored
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  DATA_W  write data
s_axi_wstrb  in  DATA_W/8  byte strobes
s_axi_wlast  in  1  last beat flag
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  ID_W  response ID
s_axi_bresp  out  2  00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
mem_we  out  1  one-cycle write pulse per accepted beat
mem_addr  out  ADDR_W  word-aligned byte address (low log2(DATA_W/8) bits 0)
mem_wdata  out  DATA_W  beat data
mem_wstrb  out  DATA_W/8  beat strobes

Behaviour:
- Reset (rst=0 at posedge): state IDLE; all outputs 0; beat counter, captured ID/addr/len/size/burst and error flag cleared. Reset mid-burst abandons the burst without a B response.
- FSM IDLE -> DATA -> RESP -> IDLE.
- IDLE:
  - awready=1 (first cycle after rst released); wready=0, bvalid=0.
  - On awvalid&&awready: capture ID, addr, len, size, burst; beat counter=0; go to DATA.
- DATA:
  - awready=0; wready=1 every cycle.
  - Per wvalid&&wready beat: next cycle mem_we=1, mem_addr=cur_addr with low bits cleared, mem_wdata/mem_wstrb = registered beat values (1-cycle latency).
  - mem_we=0 in any cycle with no beat handshake in the prior cycle.
- Address update after each beat (ADDR_W modulo arithmetic, 0xFFFF rolls to 0x0000):
  - FIXED: unchanged.
  - INCR: cur_addr += 1<<size.
  - WRAP: container = (len+1)<<size, base = start & ~(container-1); next = base + ((cur_addr + (1<<size) - base) mod container).
- Burst end: the beat where counter==len; go to RESP. Termination is by count only; wlast does not end a burst.
- wlast mismatch: wlast=1 on a non-final beat, or wlast=0 on the final beat, sets error. All beats are still written.
- Illegal request sets error at AW capture:
  - size > log2(DATA_W/8)
  - burst==11
  - WRAP with len not in {1,3,7,15}
  - Illegal-request bursts: all beats accepted, mem_we suppressed for the whole burst.
- RESP:
  - bvalid=1 the cycle after the final beat handshake, coincident with the final mem_we.
  - bid=captured ID; bresp=10 if error else 00; wready=0, awready=0.
  - Held stable until bready; on bvalid&&bready: bvalid=0, go to IDLE, awready=1 next cycle.
- One outstanding burst only. AW presented during DATA/RESP stalls (awready=0) until IDLE.
- Simultaneous bready handshake and new awvalid: AW is not accepted that cycle; it is accepted in the following IDLE cycle.

Test Plan:
- Single INCR: awaddr=0x0100, len=0, size=2, wdata=0xDEADBEEF, wstrb=F, wlast=1, bready=1 -> one mem_we at 0x0100 with 0xDEADBEEF, bresp=00, bid=awid.
- INCR len=3, size=2 from 0x0010 with wvalid gaps -> mem_we at 0x10, 0x14, 0x18, 0x1C in order, only after each handshake; bvalid once.
- WRAP len=3, size=2 at 0x0038 -> addresses 0x38, 0x3C, 0x30, 0x34; bresp=00. Same with len=2 -> no mem_we, 3 beats accepted, bresp=10.
- FIXED len=2 at 0x0200 -> three mem_we at 0x0200. INCR from 0xFFFC len=1 -> 0xFFFC then 0x0000.
- wlast=1 on beat 1 of len=3 -> 4 beats written, bresp=10. burst=11 or size=3 -> no writes, bresp=10.
- Back-pressure/reset:
  - bready=0 for 5 cycles -> bvalid, bid, bresp stable, awready=0 throughout.
  - rst=0 mid-DATA -> next cycle all outputs 0, awready=1 after release, no B response issued.
